mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter IO_ADR, default 32'h0003_0000, memory-mapped output port address subject to io_full back-pressure.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  global ready; when low, all state, counters and outputs hold.
REQ-005 ic_en_i  input  1  instruction-cache fetch request, one-cycle pulse.
REQ-006 ic_adr_i  input  32  fetch byte address, sampled with ic_en_i.
REQ-007 ic_en_o  output  1  fetch-done pulse, one cycle.
REQ-008 ic_dat_o  output  32  fetched word, little-endian, valid with ic_en_o.
REQ-009 dc_en_i  input  1  data-cache request, one-cycle pulse.
REQ-010 dc_rwen_i  input  1  1 = read, 0 = write.
REQ-011 dc_len_i  input  3  byte count; legal values 1, 2, 4.
REQ-012 dc_adr_i / dc_dat_i  input  32 / 32  byte address and store data, sampled with dc_en_i.
REQ-013 dc_en_o  output  1  data-done pulse, one cycle, for both reads and writes.
REQ-014 dc_dat_o  output  32  load data, zero-extended, little-endian, valid with dc_en_o.
REQ-015 br_flag  input  1  misprediction flush from the ROB.
REQ-016 mem_din  input  8  RAM read byte, valid one cycle after its address is driven.
REQ-017 mem_dout / mem_a / mem_wr  output  8 / 32 / 1  RAM write byte, byte address, and write strobe (1 = write).
REQ-018 io_full  input  1  I/O buffer full; stalls writes to IO_ADR.

Function
REQ-019 Each requester SHALL have one pending slot; the request pulse sets the slot and latches its fields, and the slot clears when the request is granted.
REQ-020 The FSM SHALL have states IDLE, IC_RD, DC_RD and DC_WR; grants occur only in IDLE, at most one per cycle.
REQ-021 A request pulse arriving in IDLE SHALL be grantable in the same cycle.
REQ-022 Each grant SHALL reset the byte counter k to 0.
REQ-023 In a read state, cycle k (0..n-1) SHALL drive mem_a = adr+k with mem_wr = 0.
REQ-024 Byte k SHALL be captured from mem_din in cycle k+1 into bits [8k+7:8k].
REQ-025 The done pulse SHALL be asserted in cycle n+1 after the grant cycle, followed by a return to IDLE.
REQ-026 IC reads SHALL use n = 4; DC reads SHALL use n = dc_len.
REQ-027 In DC_WR, cycle k SHALL drive mem_a = adr+k, mem_dout = dat[8k+7:8k] and mem_wr = 1.
REQ-028 dc_en_o SHALL pulse in the cycle after the last byte is written.
REQ-029 A DC_WR byte addressed to IO_ADR while io_full = 1 SHALL drive mem_wr = 0 and hold k until io_full falls.
REQ-030 In IDLE, mem_wr SHALL be 0 and mem_a SHALL be 0.
REQ-031 ic_en_o and dc_en_o SHALL never be high in the same cycle.
REQ-032 br_flag SHALL clear the IC pending slot in the same cycle.
REQ-033 br_flag SHALL abort IC_RD to IDLE on the next edge, with no ic_en_o.
REQ-034 br_flag SHALL NOT affect DC pending requests or DC_RD/DC_WR in progress.
REQ-035 An ic_en_i arriving together with br_flag SHALL be accepted as the new fetch.
REQ-036 A new request pulse SHALL be accepted in the same cycle its own done pulse is emitted.

Reset
REQ-037 While rst is high, the block SHALL hold state IDLE and clear both pending slots, k and the round-robin pointer.
REQ-038 While rst is high, all outputs SHALL be 0.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-040 With MEM_ARB_RR_EN defined, a one-bit pointer SHALL grant the requester not served last when both slots are pending.
REQ-041 With MEM_ARB_RR_EN undefined, DC SHALL always win when both slots are pending (fixed priority).

Verification
REQ-042 Given an IC fetch at 0x100 with RAM bytes 11,22,33,44, the bench SHALL see ic_dat_o = 0x44332211 with ic_en_o exactly 5 cycles after the grant.
REQ-043 Given a DC write with len 2, adr 0x200, dat 0xBEEF, the bench SHALL see writes (0x200,EF) then (0x201,BE) and dc_en_o the following cycle.
REQ-044 Given simultaneous IC and DC pulses with MEM_ARB_RR_EN undefined, the bench SHALL see DC served first and then IC; with it defined and last = DC, IC is served first.
REQ-045 Given br_flag asserted on the second cycle of IC_RD, the bench SHALL see no ic_en_o, IDLE next, and a pending DC read granted next.
REQ-046 Given a 1-byte write to 0x30000 with io_full high for 3 cycles, the bench SHALL see mem_wr = 0 for 3 cycles, then a single write and dc_en_o.
REQ-047 Given rst pulsed during a 4-byte DC read, the bench SHALL see all outputs 0, no dc_en_o, and an accepted new request after rst falls.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto a byte-wide RAM port with I/O back-pressure.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed DC-over-IC priority.
module mem_arbiter #(
    parameter logic [31:0] IO_ADR = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ic_en_i,
    input  logic [31:0] ic_adr_i,
    output logic        ic_en_o,
    output logic [31:0] ic_dat_o,
    input  logic        dc_en_i,
    input  logic        dc_rwen_i,
    input  logic [2:0]  dc_len_i,
    input  logic [31:0] dc_adr_i,
    input  logic [31:0] dc_dat_i,
    output logic        dc_en_o,
    output logic [31:0] dc_dat_o,
    input  logic        br_flag,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_full
);

    typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  k_reg, k_next;
    logic [2:0]  n_reg, n_next;
    logic [31:0] adr_reg, adr_next;
    logic [31:0] wdat_reg, wdat_next;
    logic [31:0] buf_reg, buf_next;

    logic        ic_pend_reg, ic_pend_next;
    logic [31:0] ic_adr_reg;
    logic        dc_pend_reg, dc_pend_next;
    logic        dc_rwen_reg;
    logic [2:0]  dc_len_reg;
    logic [31:0] dc_adr_reg, dc_dat_reg;

    // A pulse in the current cycle overrides the latched slot so IDLE can grant it immediately.
    logic        ic_req, dc_req, grant_ic, grant_dc;
    logic [31:0] ic_adr_eff, dc_adr_eff, dc_dat_eff;
    logic        dc_rwen_eff;
    logic [2:0]  dc_len_eff;

    assign ic_req      = (ic_pend_reg & ~br_flag) | ic_en_i;
    assign ic_adr_eff  = ic_en_i ? ic_adr_i : ic_adr_reg;
    assign dc_req      = dc_pend_reg | dc_en_i;
    assign dc_adr_eff  = dc_en_i ? dc_adr_i : dc_adr_reg;
    assign dc_dat_eff  = dc_en_i ? dc_dat_i : dc_dat_reg;
    assign dc_rwen_eff = dc_en_i ? dc_rwen_i : dc_rwen_reg;
    assign dc_len_eff  = dc_en_i ? dc_len_i : dc_len_reg;

`ifdef MEM_ARB_RR_EN
    logic last_dc_reg;
    assign grant_dc = (state_reg == IDLE) && dc_req && (!ic_req || !last_dc_reg);
`else
    assign grant_dc = (state_reg == IDLE) && dc_req;
`endif
    assign grant_ic = (state_reg == IDLE) && ic_req && !grant_dc;

    logic        active, stall;
    logic [31:0] cur_adr;
    logic [31:0] wdat_sh;
    logic [31:0] rd_asm;

    assign active  = k_reg < n_reg;
    assign cur_adr = adr_reg + {29'd0, k_reg};
    assign wdat_sh = wdat_reg >> {k_reg, 3'b000};
    assign stall   = (state_reg == DC_WR) && active && (cur_adr == IO_ADR) && io_full;

    // Byte k-1 arrives on mem_din while k is current, so the done cycle sees the full word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_asm[8*gi +: 8] = (k_reg == 3'(gi + 1)) ? mem_din : buf_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        n_next       = n_reg;
        adr_next     = adr_reg;
        wdat_next    = wdat_reg;
        buf_next     = buf_reg;
        ic_pend_next = grant_ic ? 1'b0 : ic_req;
        dc_pend_next = grant_dc ? 1'b0 : dc_req;
        ic_en_o      = 1'b0;
        ic_dat_o     = 32'd0;
        dc_en_o      = 1'b0;
        dc_dat_o     = 32'd0;
        mem_a        = 32'd0;
        mem_dout     = 8'd0;
        mem_wr       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_dc) begin
                    state_next = dc_rwen_eff ? DC_RD : DC_WR;
                    n_next     = dc_len_eff;
                    adr_next   = dc_adr_eff;
                    wdat_next  = dc_dat_eff;
                    k_next     = 3'd0;
                    buf_next   = 32'd0;
                end else if (grant_ic) begin
                    state_next = IC_RD;
                    n_next     = 3'd4;
                    adr_next   = ic_adr_eff;
                    k_next     = 3'd0;
                    buf_next   = 32'd0;
                end
            end
            IC_RD: begin
                if (br_flag) begin
                    state_next = IDLE;
                end else if (active) begin
                    mem_a    = cur_adr;
                    k_next   = k_reg + 3'd1;
                    buf_next = rd_asm;
                end else begin
                    ic_en_o    = 1'b1;
                    ic_dat_o   = rd_asm;
                    state_next = IDLE;
                end
            end
            DC_RD: begin
                if (active) begin
                    mem_a    = cur_adr;
                    k_next   = k_reg + 3'd1;
                    buf_next = rd_asm;
                end else begin
                    dc_en_o    = 1'b1;
                    dc_dat_o   = rd_asm;
                    state_next = IDLE;
                end
            end
            DC_WR: begin
                if (active) begin
                    mem_a    = cur_adr;
                    mem_dout = wdat_sh[7:0];
                    mem_wr   = !stall;
                    if (!stall) begin
                        k_next = k_reg + 3'd1;
                    end
                end else begin
                    dc_en_o    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= 3'd0;
            n_reg       <= 3'd0;
            adr_reg     <= 32'd0;
            wdat_reg    <= 32'd0;
            buf_reg     <= 32'd0;
            ic_pend_reg <= 1'b0;
            ic_adr_reg  <= 32'd0;
            dc_pend_reg <= 1'b0;
            dc_rwen_reg <= 1'b0;
            dc_len_reg  <= 3'd0;
            dc_adr_reg  <= 32'd0;
            dc_dat_reg  <= 32'd0;
        end else if (en) begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            n_reg       <= n_next;
            adr_reg     <= adr_next;
            wdat_reg    <= wdat_next;
            buf_reg     <= buf_next;
            ic_pend_reg <= ic_pend_next;
            dc_pend_reg <= dc_pend_next;
            if (ic_en_i) begin
                ic_adr_reg <= ic_adr_i;
            end
            if (dc_en_i) begin
                dc_rwen_reg <= dc_rwen_i;
                dc_len_reg  <= dc_len_i;
                dc_adr_reg  <= dc_adr_i;
                dc_dat_reg  <= dc_dat_i;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dc_reg <= 1'b0;
        end else if (en) begin
            if (grant_dc) begin
                last_dc_reg <= 1'b1;
            end else if (grant_ic) begin
                last_dc_reg <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte RAM (one-cycle read latency).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        ic_en_i = 1'b0;
    logic [31:0] ic_adr_i = 32'd0;
    logic        ic_en_o;
    logic [31:0] ic_dat_o;
    logic        dc_en_i = 1'b0;
    logic        dc_rwen_i = 1'b0;
    logic [2:0]  dc_len_i = 3'd0;
    logic [31:0] dc_adr_i = 32'd0;
    logic [31:0] dc_dat_i = 32'd0;
    logic        dc_en_o;
    logic [31:0] dc_dat_o;
    logic        br_flag = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full = 1'b0;

    logic [7:0] ram [0:4095];
    int n_tests = 0;
    int n_fail = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .en(en),
        .ic_en_i(ic_en_i), .ic_adr_i(ic_adr_i), .ic_en_o(ic_en_o), .ic_dat_o(ic_dat_o),
        .dc_en_i(dc_en_i), .dc_rwen_i(dc_rwen_i), .dc_len_i(dc_len_i),
        .dc_adr_i(dc_adr_i), .dc_dat_i(dc_dat_i), .dc_en_o(dc_en_o), .dc_dat_o(dc_dat_o),
        .br_flag(br_flag), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_full(io_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Start a new cycle just after the rising edge; request pulses last one cycle.
    task automatic advance();
        @(posedge clk);
        #1;
        ic_en_i = 1'b0;
        dc_en_i = 1'b0;
        br_flag = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {29'd0, ic_en_o, dc_en_o, mem_wr}, 32'd0);
        check_eq({tag, "_mem_a"}, mem_a, 32'd0);
        check_eq({tag, "_dats"}, ic_dat_o | dc_dat_o | {24'd0, mem_dout}, 32'd0);
    endtask

    initial begin
        int ic_cyc, dc_cyc, both, wr_cnt, ic_cnt;
        logic [31:0] ic_word, dc_word, wr_a, wr_d;

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h300] = 8'hA1; ram[12'h301] = 8'hB2; ram[12'h302] = 8'hC3; ram[12'h303] = 8'hD4;

        // Reset: a pulse during reset must not leave anything pending.
        advance(); ic_en_i = 1'b1; ic_adr_i = 32'h100;
        sample(); check_all_zero("rst");
        advance(); sample(); check_all_zero("rst_hold");
        @(posedge clk); #1; rst = 1'b0;
        advance(); sample(); check_eq("post_rst_idle_a", mem_a, 32'd0);

        // IC fetch at 0x100: four byte addresses, then done 5 cycles after the grant.
        advance(); ic_en_i = 1'b1; ic_adr_i = 32'h100;
        sample(); check_eq("ic_grant_a", mem_a, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            advance(); sample();
            check_eq($sformatf("ic_done_c%0d", i), {31'd0, ic_en_o}, {31'd0, i == 5});
            check_eq($sformatf("ic_a_c%0d", i), mem_a, (i <= 4) ? 32'h100 + i - 1 : 32'd0);
            if (i == 5) check_eq("ic_word", ic_dat_o, 32'h44332211);
        end

        // DC write, 2 bytes of 0xBEEF to 0x200.
        advance(); dc_en_i = 1'b1; dc_rwen_i = 1'b0; dc_len_i = 3'd2;
        dc_adr_i = 32'h200; dc_dat_i = 32'h0000BEEF;
        sample();
        advance(); sample(); check_eq("wr0", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h00, 8'hEF});
        check_eq("wr0_a", mem_a, 32'h200);
        advance(); sample(); check_eq("wr1", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h01, 8'hBE});
        advance(); sample(); check_eq("wr_done", {30'd0, dc_en_o, mem_wr}, 32'd2);
        advance(); sample(); check_eq("wr_ram", {16'd0, ram[12'h201], ram[12'h200]}, 32'h0000BEEF);

        // DC read, 2 bytes from 0x300, zero-extended.
        advance(); dc_en_i = 1'b1; dc_rwen_i = 1'b1; dc_len_i = 3'd2; dc_adr_i = 32'h300;
        sample();
        advance(); sample(); advance(); sample();
        advance(); sample();
        check_eq("rd2_done", {31'd0, dc_en_o}, 32'd1);
        check_eq("rd2_word", dc_dat_o, 32'h0000B2A1);
        advance(); sample();

        // Simultaneous requests; the last grant was DC.
        advance(); ic_en_i = 1'b1; ic_adr_i = 32'h100;
        dc_en_i = 1'b1; dc_rwen_i = 1'b1; dc_len_i = 3'd1; dc_adr_i = 32'h300;
        sample();
        ic_cyc = 0; dc_cyc = 0; both = 0; ic_word = 0; dc_word = 0;
        for (int i = 1; i <= 9; i++) begin
            advance(); sample();
            if (ic_en_o) begin ic_cyc = i; ic_word = ic_dat_o; end
            if (dc_en_o) begin dc_cyc = i; dc_word = dc_dat_o; end
            if (ic_en_o && dc_en_o) both++;
        end
`ifdef MEM_ARB_RR_EN
        check_eq("arb_ic_cycle", ic_cyc, 5);
        check_eq("arb_dc_cycle", dc_cyc, 8);
`else
        check_eq("arb_ic_cycle", ic_cyc, 8);
        check_eq("arb_dc_cycle", dc_cyc, 2);
`endif
        check_eq("arb_ic_word", ic_word, 32'h44332211);
        check_eq("arb_dc_word", dc_word, 32'h000000A1);
        check_eq("arb_both_high", both, 0);

        // Flush on the second IC_RD cycle with a DC read waiting.
        advance(); ic_en_i = 1'b1; ic_adr_i = 32'h100; sample();
        advance(); dc_en_i = 1'b1; dc_rwen_i = 1'b1; dc_len_i = 3'd4; dc_adr_i = 32'h300;
        sample(); check_eq("br_k0_a", mem_a, 32'h100);
        advance(); br_flag = 1'b1; sample();
        ic_cnt = ic_en_o ? 1 : 0;
        advance(); sample(); check_eq("br_idle_a", mem_a, 32'd0);
        ic_cnt += ic_en_o ? 1 : 0;
        dc_cyc = 0; dc_word = 0;
        for (int i = 4; i <= 9; i++) begin
            advance(); sample();
            if (i == 4) check_eq("br_dc_a", mem_a, 32'h300);
            ic_cnt += ic_en_o ? 1 : 0;
            if (dc_en_o) begin dc_cyc = i; dc_word = dc_dat_o; end
        end
        check_eq("br_no_ic_done", ic_cnt, 0);
        check_eq("br_dc_cycle", dc_cyc, 8);
        check_eq("br_dc_word", dc_word, 32'hD4C3B2A1);

        // I/O write stalled by io_full for three cycles.
        advance(); io_full = 1'b1; dc_en_i = 1'b1; dc_rwen_i = 1'b0; dc_len_i = 3'd1;
        dc_adr_i = 32'h0003_0000; dc_dat_i = 32'h0000005A;
        sample();
        wr_cnt = 0; dc_cyc = 0; wr_a = 0; wr_d = 0;
        for (int i = 1; i <= 6; i++) begin
            advance();
            if (i == 4) io_full = 1'b0;
            sample();
            if (i <= 3) check_eq($sformatf("io_stall_c%0d", i), {31'd0, mem_wr}, 32'd0);
            if (mem_wr) begin wr_cnt++; wr_a = mem_a; wr_d = {24'd0, mem_dout}; end
            if (dc_en_o) dc_cyc = i;
        end
        check_eq("io_wr_count", wr_cnt, 1);
        check_eq("io_wr_a", wr_a, 32'h0003_0000);
        check_eq("io_wr_d", wr_d, 32'h5A);
        check_eq("io_done_cycle", dc_cyc, 5);

        // Reset in the middle of a 4-byte DC read.
        advance(); dc_en_i = 1'b1; dc_rwen_i = 1'b1; dc_len_i = 3'd4; dc_adr_i = 32'h300;
        sample();
        advance(); sample();
        advance(); rst = 1'b1; sample(); check_all_zero("midrst");
        advance(); sample();
        advance(); rst = 1'b0; sample();
        dc_cyc = 0;
        for (int i = 1; i <= 6; i++) begin
            advance(); sample();
            if (dc_en_o) dc_cyc = i;
        end
        check_eq("midrst_no_done", dc_cyc, 0);
        advance(); dc_en_i = 1'b1; dc_rwen_i = 1'b1; dc_len_i = 3'd1; dc_adr_i = 32'h303;
        sample();
        advance(); sample();
        advance(); sample();
        check_eq("midrst_new_done", {31'd0, dc_en_o}, 32'd1);
        check_eq("midrst_new_word", dc_dat_o, 32'h000000D4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
